// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle: upstream instruction fields with valid/ready,
// downstream registered fields with mem_ready back-pressure, plus redirect/debug.
interface ex_stage_if #(
  parameter int XLEN = 64
);
  // Handshake: a transfer happens on a clock edge where the sender's valid and
  // the receiver's ready are both high; the sender holds its fields until then.
  logic            expr_ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] expr_ex_final_a;
  logic [XLEN-1:0] expr_ex_final_b;
  logic [2:0]      expr_ex_alu_op;
  logic            expr_ex_sub;
  logic            expr_ex_slt_and_spin_off_signed;
  logic            expr_ex_slt_and_spin_off_unsigned;
  logic            expr_ex_word_op;
  logic            expr_ex_is_write_dmem;
  logic [1:0]      expr_ex_wb_select;
  logic [7:0]      expr_ex_write_width;
  logic [XLEN-1:0] expr_ex_dmem_write_data;
  logic            expr_ex_pc_sel;

  logic            mem_ready;
  logic            exmem_valid;
  logic [XLEN-1:0] exmem_alu_result;
  logic            exmem_is_write_dmem;
  logic [1:0]      exmem_wb_select;
  logic [7:0]      exmem_write_width;
  logic [XLEN-1:0] exmem_dmem_write_data;
  logic            ex_redirect;
  logic [1:0]      ex_squash_cnt;

  modport master (
    output expr_ex_valid, expr_ex_final_a, expr_ex_final_b, expr_ex_alu_op,
           expr_ex_sub, expr_ex_slt_and_spin_off_signed,
           expr_ex_slt_and_spin_off_unsigned, expr_ex_word_op,
           expr_ex_is_write_dmem, expr_ex_wb_select, expr_ex_write_width,
           expr_ex_dmem_write_data, expr_ex_pc_sel, mem_ready,
    input  ex_ready, exmem_valid, exmem_alu_result, exmem_is_write_dmem,
           exmem_wb_select, exmem_write_width, exmem_dmem_write_data,
           ex_redirect, ex_squash_cnt
  );

  modport slave (
    input  expr_ex_valid, expr_ex_final_a, expr_ex_final_b, expr_ex_alu_op,
           expr_ex_sub, expr_ex_slt_and_spin_off_signed,
           expr_ex_slt_and_spin_off_unsigned, expr_ex_word_op,
           expr_ex_is_write_dmem, expr_ex_wb_select, expr_ex_write_width,
           expr_ex_dmem_write_data, expr_ex_pc_sel, mem_ready,
    output ex_ready, exmem_valid, exmem_alu_result, exmem_is_write_dmem,
           exmem_wb_select, exmem_write_width, exmem_dmem_write_data,
           ex_redirect, ex_squash_cnt
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU on ID/EX operands, registered into EX/MEM with valid/ready
// stall handling and squashing of the instructions in a taken redirect's shadow.
module ex_stage #(
  parameter int XLEN          = 64,
  parameter int BRANCH_SHADOW = 2
) (
  input  logic     sys_clk,
  input  logic     sys_rst,
  ex_stage_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} squash_state_e;

  localparam logic [1:0] SHADOW_CNT = 2'(BRANCH_SHADOW);

  logic            accept;
  logic            ready_w;
  logic            in_shadow;
  logic            redirect_w;
  squash_state_e   squash_state;
  logic [1:0]      cnt_q, cnt_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            is_wr_q, is_wr_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [7:0]      wr_width_q, wr_width_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res64;
  logic [31:0]     res32;
  logic [31:0]     a_w, b_w;
  logic [5:0]      sh;
  logic            lt;

  // Reset also forces ready low so nothing is accepted while it is held.
  assign ready_w = !sys_rst && (!valid_q || bus.mem_ready);
  assign accept  = bus.expr_ex_valid && ready_w;

  // ---------------- ALU ----------------
  always_comb begin
    a_w   = bus.expr_ex_final_a[31:0];
    b_w   = bus.expr_ex_final_b[31:0];
    sh    = bus.expr_ex_word_op ? {1'b0, bus.expr_ex_final_b[4:0]}
                                : bus.expr_ex_final_b[5:0];
    res64 = '0;
    res32 = '0;
    lt    = 1'b0;
    case (bus.expr_ex_alu_op)
      3'b000: begin
        if (bus.expr_ex_sub) begin
          res64 = bus.expr_ex_final_a - bus.expr_ex_final_b;
          res32 = a_w - b_w;
        end else begin
          res64 = bus.expr_ex_final_a + bus.expr_ex_final_b;
          res32 = a_w + b_w;
        end
      end
      3'b001: begin
        res64 = bus.expr_ex_final_a << sh;
        res32 = a_w << sh[4:0];
      end
      3'b010: begin
        // Unsigned flag takes priority; otherwise the compare is signed.
        casez ({bus.expr_ex_slt_and_spin_off_unsigned, bus.expr_ex_slt_and_spin_off_signed})
          2'b1?:   lt = bus.expr_ex_final_a < bus.expr_ex_final_b;
          2'b01:   lt = $signed(bus.expr_ex_final_a) < $signed(bus.expr_ex_final_b);
          default: lt = $signed(bus.expr_ex_final_a) < $signed(bus.expr_ex_final_b);
        endcase
        res64 = {{(XLEN-1){1'b0}}, lt};
      end
      3'b011: begin
        res64 = bus.expr_ex_final_a ^ bus.expr_ex_final_b;
        res32 = a_w ^ b_w;
      end
      3'b100: begin
        if (bus.expr_ex_sub) begin
          res64 = $signed(bus.expr_ex_final_a) >>> sh;
          res32 = $signed(a_w) >>> sh[4:0];
        end else begin
          res64 = bus.expr_ex_final_a >> sh;
          res32 = a_w >> sh[4:0];
        end
      end
      3'b101: begin
        res64 = bus.expr_ex_final_a | bus.expr_ex_final_b;
        res32 = a_w | b_w;
      end
      3'b110: begin
        res64 = bus.expr_ex_final_a & bus.expr_ex_final_b;
        res32 = a_w & b_w;
      end
      default: begin
        res64 = bus.expr_ex_final_b;
        res32 = b_w;
      end
    endcase
    // Compares always produce a full-width 0/1, even for word ops.
    if (bus.expr_ex_word_op && (bus.expr_ex_alu_op != 3'b010))
      alu_res = {{(XLEN-32){res32[31]}}, res32};
    else
      alu_res = res64;
  end

  // ---------------- squash FSM ----------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= 2'd0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (in_shadow)              cnt_d = cnt_q - 2'd1;
      else if (bus.expr_ex_pc_sel) cnt_d = SHADOW_CNT;
    end
  end

  always_comb begin
    squash_state = (cnt_q == 2'd0) ? IDLE : SHADOW;
    in_shadow    = (squash_state == SHADOW);
    redirect_w   = accept && !in_shadow && bus.expr_ex_pc_sel;
  end

  // ---------------- EX/MEM register ----------------
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    is_wr_d    = is_wr_q;
    wb_sel_d   = wb_sel_q;
    wr_width_d = wr_width_q;
    wr_data_d  = wr_data_q;
    if (accept) begin
      // Squashed instructions still load their data but travel as a bubble.
      valid_d    = !in_shadow;
      result_d   = alu_res;
      is_wr_d    = bus.expr_ex_is_write_dmem;
      wb_sel_d   = bus.expr_ex_wb_select;
      wr_width_d = bus.expr_ex_write_width;
      wr_data_d  = bus.expr_ex_dmem_write_data;
    end else if (bus.mem_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      is_wr_q    <= 1'b0;
      wb_sel_q   <= 2'd0;
      wr_width_q <= 8'd0;
      wr_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      is_wr_q    <= is_wr_d;
      wb_sel_q   <= wb_sel_d;
      wr_width_q <= wr_width_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.ex_ready              = ready_w;
  assign bus.ex_redirect           = redirect_w;
  assign bus.ex_squash_cnt         = cnt_q;
  assign bus.exmem_valid           = valid_q;
  assign bus.exmem_alu_result      = result_q;
  assign bus.exmem_is_write_dmem   = is_wr_q;
  assign bus.exmem_wb_select       = wb_sel_q;
  assign bus.exmem_write_width     = wr_width_q;
  assign bus.exmem_dmem_write_data = wr_data_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU vectors, stall, redirect shadow, reset in shadow.
module tb_ex_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ex_stage_if #(.XLEN(64)) bus ();

  ex_stage #(.XLEN(64), .BRANCH_SHADOW(2)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [2:0] op, input logic sub,
                       input logic sgn, input logic uns, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input logic pc_sel);
    bus.expr_ex_valid                     = valid;
    bus.expr_ex_alu_op                    = op;
    bus.expr_ex_sub                       = sub;
    bus.expr_ex_slt_and_spin_off_signed   = sgn;
    bus.expr_ex_slt_and_spin_off_unsigned = uns;
    bus.expr_ex_word_op                   = word;
    bus.expr_ex_final_a                   = a;
    bus.expr_ex_final_b                   = b;
    bus.expr_ex_pc_sel                    = pc_sel;
    bus.expr_ex_is_write_dmem             = 1'b0;
    bus.expr_ex_wb_select                 = 2'd0;
    bus.expr_ex_write_width               = 8'd0;
    bus.expr_ex_dmem_write_data           = 64'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
    bus.expr_ex_is_write_dmem   = 1'b1;
    bus.expr_ex_wb_select       = 2'd3;
    bus.expr_ex_write_width     = 8'hFF;
    bus.expr_ex_dmem_write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.mem_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.exmem_valid); end
    n_checks++;
    if (bus.exmem_alu_result !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", bus.exmem_alu_result); end
    n_checks++;
    if ({bus.exmem_is_write_dmem, bus.exmem_wb_select, bus.exmem_write_width} !== 11'd0 ||
        bus.exmem_dmem_write_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_fields got=%b/%h/%h/%h exp=0", bus.exmem_is_write_dmem,
                         bus.exmem_wb_select, bus.exmem_write_width, bus.exmem_dmem_write_data);
    end
    n_checks++;
    if (bus.ex_redirect !== 1'b0 || bus.ex_ready !== 1'b0 || bus.ex_squash_cnt !== 2'd0) begin
      n_fail++; $display("FAIL reset_ctrl got redirect=%b ready=%b cnt=%0d exp=0/0/0",
                         bus.ex_redirect, bus.ex_ready, bus.ex_squash_cnt);
    end
    // release: 5 - 3 with store pass-through fields
    rst = 1'b0;
    drive(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 64'd5, 64'd3, 1'b0);
    bus.expr_ex_is_write_dmem   = 1'b1;
    bus.expr_ex_wb_select       = 2'd2;
    bus.expr_ex_write_width     = 8'hF0;
    bus.expr_ex_dmem_write_data = 64'h1234;
    bus.mem_ready = 1'b1;
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'd2) begin
      n_fail++; $display("FAIL first_sub got valid=%b res=%h exp=1/2", bus.exmem_valid, bus.exmem_alu_result);
    end
    n_checks++;
    if (bus.exmem_is_write_dmem !== 1'b1 || bus.exmem_wb_select !== 2'd2 ||
        bus.exmem_write_width !== 8'hF0 || bus.exmem_dmem_write_data !== 64'h1234) begin
      n_fail++; $display("FAIL passthru got=%b/%h/%h/%h exp=1/2/f0/1234", bus.exmem_is_write_dmem,
                         bus.exmem_wb_select, bus.exmem_write_width, bus.exmem_dmem_write_data);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        sub, sgn, uns, word;
    logic [63:0] a, b, exp;
  } vec_t;

  task automatic test_alu();
    vec_t v[17];
    v[0]  = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000};
    v[1]  = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000};
    v[2]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    v[3]  = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    v[4]  = '{3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    v[5]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0};
    v[6]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd63, 64'h8000_0000_0000_0000};
    v[7]  = '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1, 64'h3F, 64'hFFFF_FFFF_8000_0000};
    v[8]  = '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00};
    v[9]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
    v[10] = '{3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    v[11] = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 64'hF0, 64'h0F, 64'hFF};
    v[12] = '{3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFF00, 64'h0FF0, 64'h0F00};
    v[13] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 64'd7, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    v[14] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 64'd7, 64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_8000_0001};
    v[15] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    v[16] = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000};
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, v[i].op, v[i].sub, v[i].sgn, v[i].uns, v[i].word, v[i].a, v[i].b, 1'b0);
      step();
      n_checks++;
      if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== v[i].exp) begin
        n_fail++; $display("FAIL alu_vec%0d got valid=%b res=%h exp=1/%h", i,
                           bus.exmem_valid, bus.exmem_alu_result, v[i].exp);
      end
    end
  endtask

  task automatic test_stall();
    bus.mem_ready = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd23, 1'b0);
    step();
    bus.mem_ready = 1'b0;
    drive(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 64'h10, 64'h01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready%0d got=%b exp=0", i, bus.ex_ready); end
      step();
      n_checks++;
      if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'd123) begin
        n_fail++; $display("FAIL stall_hold%0d got valid=%b res=%h exp=1/7b", i,
                           bus.exmem_valid, bus.exmem_alu_result);
      end
    end
    bus.mem_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got=%b exp=1", bus.ex_ready); end
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'h11) begin
      n_fail++; $display("FAIL stall_accept got valid=%b res=%h exp=1/11", bus.exmem_valid, bus.exmem_alu_result);
    end
    bus.expr_ex_valid = 1'b0;
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", bus.exmem_valid); end
  endtask

  task automatic test_redirect();
    bus.mem_ready = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 1'b1);
    #1;
    n_checks++;
    if (bus.ex_redirect !== 1'b1) begin n_fail++; $display("FAIL redirect_pulse got=%b exp=1", bus.ex_redirect); end
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.ex_squash_cnt !== 2'd2) begin
      n_fail++; $display("FAIL redirect_issue got valid=%b cnt=%0d exp=1/2", bus.exmem_valid, bus.ex_squash_cnt);
    end
    // first shadow instruction also has pc_sel; it must be ignored
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd10, 64'd1, 1'b1);
    #1;
    n_checks++;
    if (bus.ex_redirect !== 1'b0) begin n_fail++; $display("FAIL shadow_no_pulse got=%b exp=0", bus.ex_redirect); end
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b0 || bus.ex_squash_cnt !== 2'd1 || bus.exmem_alu_result !== 64'd11) begin
      n_fail++; $display("FAIL shadow1 got valid=%b cnt=%0d res=%h exp=0/1/b", bus.exmem_valid,
                         bus.ex_squash_cnt, bus.exmem_alu_result);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd20, 64'd2, 1'b0);
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b0 || bus.ex_squash_cnt !== 2'd0) begin
      n_fail++; $display("FAIL shadow2 got valid=%b cnt=%0d exp=0/0", bus.exmem_valid, bus.ex_squash_cnt);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd30, 64'd3, 1'b0);
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'd33) begin
      n_fail++; $display("FAIL after_shadow got valid=%b res=%h exp=1/21", bus.exmem_valid, bus.exmem_alu_result);
    end
    // again, with idle cycles inside the shadow
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 1'b1);
    step();
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2, 1'b0);
    step();
    bus.expr_ex_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.ex_squash_cnt !== 2'd1 || bus.exmem_valid !== 1'b0) begin
      n_fail++; $display("FAIL shadow_hold got cnt=%0d valid=%b exp=1/0", bus.ex_squash_cnt, bus.exmem_valid);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd4, 64'd4, 1'b0);
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b0 || bus.ex_squash_cnt !== 2'd0) begin
      n_fail++; $display("FAIL shadow_hold_sq got valid=%b cnt=%0d exp=0/0", bus.exmem_valid, bus.ex_squash_cnt);
    end
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd5, 1'b0);
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'd10) begin
      n_fail++; $display("FAIL shadow_hold_end got valid=%b res=%h exp=1/a", bus.exmem_valid, bus.exmem_alu_result);
    end
  endtask

  task automatic test_reset_in_shadow();
    bus.mem_ready = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1, 1'b1);
    step();
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2, 1'b0);
    step();
    n_checks++;
    if (bus.ex_squash_cnt !== 2'd1) begin n_fail++; $display("FAIL pre_rst_cnt got=%0d exp=1", bus.ex_squash_cnt); end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.ex_squash_cnt !== 2'd0 || bus.exmem_valid !== 1'b0 || bus.exmem_alu_result !== 64'd0) begin
      n_fail++; $display("FAIL rst_shadow got cnt=%0d valid=%b res=%h exp=0/0/0", bus.ex_squash_cnt,
                         bus.exmem_valid, bus.exmem_alu_result);
    end
    rst = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'd6, 64'd7, 1'b0);
    step();
    n_checks++;
    if (bus.exmem_valid !== 1'b1 || bus.exmem_alu_result !== 64'd13) begin
      n_fail++; $display("FAIL post_rst_first got valid=%b res=%h exp=1/d", bus.exmem_valid, bus.exmem_alu_result);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu();
    test_stall();
    test_redirect();
    test_reset_in_shadow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
